// File: rtl/instr_mem_loadable_pkg.sv
// Shared definitions for the loadable instruction memory: FSM states,
// instruction opcodes, LED colours and the default fill word.
package instr_mem_loadable_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_WAIT = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_LED  = 4'h7;

  localparam logic [23:0] COLOUR_OFF   = 24'h000000;
  localparam logic [23:0] COLOUR_RED   = 24'hFF0000;
  localparam logic [23:0] COLOUR_GREEN = 24'h00FF00;
  localparam logic [23:0] COLOUR_BLUE  = 24'h0000FF;

  // Unprogrammed locations hold an LED instruction with an alternating bit pattern
  localparam logic [27:0] FILL_WORD_DEFAULT = {OP_LED, 24'b10101010};

endpackage

// File: rtl/instr_mem_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port
// with enable, no reset on storage or read register.
module instr_mem_ram #(
  parameter int DATA_W = 28,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// Instruction memory that fills itself after reset, serves fetches in RUN
// and accepts a sequential program download in LOAD.
module instr_mem_loadable
  import instr_mem_loadable_pkg::*;
#(
  parameter int                DATA_W    = 28,
  parameter int                ADDR_W    = 8,
  parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(FILL_WORD_DEFAULT)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [15:0]       iAddress,
  input  logic              iFetch,
  output logic [DATA_W-1:0] oInstruction,
  output logic              oValid,
  input  logic              iLoadMode,
  input  logic              iLoadWrite,
  input  logic [DATA_W-1:0] iLoadData,
  output logic              oReady,
  output logic [ADDR_W:0]   oLoadCount
);

  localparam int              DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] initcount;
  logic [ADDR_W-1:0] loadptr;
  logic              have_data;
  logic              oor_q;
  logic              in_range;
  logic              load_full;
  logic              do_load;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Any set bit above the index range means out of range; no aliasing
  assign in_range  = (iAddress >> ADDR_W) == 16'd0;
  assign load_full = (oLoadCount == FULL_COUNT);
  assign do_load   = (state == ST_LOAD) && iLoadWrite && !load_full;
  assign ram_re    = (state == ST_RUN) && iFetch && !iLoadMode && in_range;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = initcount;
    ram_wdata = FILL_WORD;
    if (state == ST_INIT) begin
      ram_we = 1'b1;
    end else if (do_load) begin
      ram_we    = 1'b1;
      ram_waddr = loadptr;
      ram_wdata = iLoadData;
    end
  end

  instr_mem_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clock(Clock),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(iAddress[ADDR_W-1:0]),
    .rdata(ram_rdata)
  );

  // The RAM read register has no reset, so have_data forces zero until the first fetch
  assign oInstruction = !have_data ? '0 : (oor_q ? FILL_WORD : ram_rdata);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= ST_INIT;
      initcount  <= '0;
      loadptr    <= '0;
      oLoadCount <= '0;
      oValid     <= 1'b0;
      oReady     <= 1'b0;
      have_data  <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          initcount <= initcount + 1'b1;
          if (initcount == ADDR_W'(DEPTH-1)) begin
            state  <= ST_RUN;
            oReady <= 1'b1;
          end
        end
        ST_RUN: begin
          if (iLoadMode) begin
            state      <= ST_LOAD;
            oReady     <= 1'b0;
            oValid     <= 1'b0;
            loadptr    <= '0;
            oLoadCount <= '0;
          end else begin
            oValid <= iFetch;
            if (iFetch) begin
              have_data <= 1'b1;
              oor_q     <= !in_range;
            end
          end
        end
        ST_LOAD: begin
          oValid <= 1'b0;
          if (do_load) begin
            loadptr    <= loadptr + 1'b1;
            oLoadCount <= oLoadCount + 1'b1;
          end
          // A write in the exit cycle still lands before RUN resumes
          if (!iLoadMode) begin
            state  <= ST_RUN;
            oReady <= 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: a 16-deep and a 256-deep instance
// share stimulus; each task checks its own scenario inline.
module tb_instr_mem_loadable;

  localparam logic [27:0] FILL = 28'h70000AA;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] iAddress;
  logic        iFetch;
  logic        iLoadMode;
  logic        iLoadWrite;
  logic [27:0] iLoadData;

  logic [27:0] inst4;
  logic        valid4;
  logic        ready4;
  logic [4:0]  count4;
  logic [27:0] inst8;
  logic        valid8;
  logic        ready8;
  logic [8:0]  count8;

  int nVectors = 0;
  int nMiscompares = 0;

  always #5 Clock = ~Clock;

  instr_mem_loadable #(.DATA_W(28), .ADDR_W(4)) dut4 (
    .Clock(Clock), .Reset(Reset), .iAddress(iAddress), .iFetch(iFetch),
    .oInstruction(inst4), .oValid(valid4), .iLoadMode(iLoadMode),
    .iLoadWrite(iLoadWrite), .iLoadData(iLoadData), .oReady(ready4),
    .oLoadCount(count4)
  );

  instr_mem_loadable #(.DATA_W(28), .ADDR_W(8)) dut8 (
    .Clock(Clock), .Reset(Reset), .iAddress(iAddress), .iFetch(iFetch),
    .oInstruction(inst8), .oValid(valid8), .iLoadMode(iLoadMode),
    .iLoadWrite(iLoadWrite), .iLoadData(iLoadData), .oReady(ready8),
    .oLoadCount(count8)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic fetch_at(input logic [15:0] a);
    iAddress = a;
    iFetch   = 1'b1;
    tick();
    iFetch   = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    Reset = 1'b0; iAddress = '0; iFetch = 1'b0;
    iLoadMode = 1'b0; iLoadWrite = 1'b0; iLoadData = '0;
    tick(); tick();
    nVectors++; if (inst4 !== 28'h0) begin nMiscompares++; $display("[TB] FAIL reset_inst got %h expected %h", inst4, 28'h0); end
    nVectors++; if (valid4 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_valid got %b expected 0", valid4); end
    nVectors++; if (ready4 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_ready got %b expected 0", ready4); end
    nVectors++; if (count4 !== 5'd0) begin nMiscompares++; $display("[TB] FAIL reset_count got %0d expected 0", count4); end
    Reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) begin
        nVectors++; if (ready4 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL init_ready_early got %b expected 0", ready4); end
      end
      if (k == 16) begin
        nVectors++; if (ready4 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL init_ready_16 got %b expected 1", ready4); end
      end
    end
    n = 0;
    while (ready8 !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    nVectors++; if (ready8 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL init8_timeout got %b expected 1", ready8); end
  endtask

  task automatic test_fill_fetch();
    for (int a = 0; a < 16; a++) begin
      fetch_at(16'(a));
      nVectors++; if (valid4 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL fill_valid[%0d] got %b expected 1", a, valid4); end
      nVectors++; if (inst4 !== FILL) begin nMiscompares++; $display("[TB] FAIL fill_data[%0d] got %h expected %h", a, inst4, FILL); end
    end
    tick();
    nVectors++; if (valid4 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL idle_valid got %b expected 0", valid4); end
  endtask

  task automatic test_load_three();
    logic [27:0] w [3];
    logic [27:0] exp4 [4];
    w    = '{28'h0A, 28'h0B, 28'h0C};
    exp4 = '{28'h0A, 28'h0B, 28'h0C, FILL};
    iLoadMode = 1'b1;
    tick();
    nVectors++; if (ready4 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL load_ready got %b expected 0", ready4); end
    nVectors++; if (count4 !== 5'd0) begin nMiscompares++; $display("[TB] FAIL load_count0 got %0d expected 0", count4); end
    for (int i = 0; i < 3; i++) begin
      iLoadWrite = 1'b1; iLoadData = w[i];
      iFetch = 1'b1; iAddress = 16'd0;
      tick();
      nVectors++; if (valid4 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL load_fetch_valid got %b expected 0", valid4); end
    end
    iLoadWrite = 1'b0; iFetch = 1'b0; iLoadMode = 1'b0;
    tick();
    nVectors++; if (ready4 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL load3_ready got %b expected 1", ready4); end
    nVectors++; if (count4 !== 5'd3) begin nMiscompares++; $display("[TB] FAIL load3_count got %0d expected 3", count4); end
    for (int a = 0; a < 4; a++) begin
      fetch_at(16'(a));
      nVectors++; if (inst4 !== exp4[a]) begin nMiscompares++; $display("[TB] FAIL load3_fetch[%0d] got %h expected %h", a, inst4, exp4[a]); end
    end
    fetch_at(16'd1);
    tick();
    nVectors++; if (inst4 !== 28'h0B) begin nMiscompares++; $display("[TB] FAIL hold_inst got %h expected %h", inst4, 28'h0B); end
    nVectors++; if (valid4 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL hold_valid got %b expected 0", valid4); end
  endtask

  task automatic test_out_of_range();
    fetch_at(16'd16);
    nVectors++; if (inst4 !== FILL) begin nMiscompares++; $display("[TB] FAIL oor4_16 got %h expected %h", inst4, FILL); end
    nVectors++; if (valid4 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL oor4_valid got %b expected 1", valid4); end
    fetch_at(16'h8000);
    nVectors++; if (inst4 !== FILL) begin nMiscompares++; $display("[TB] FAIL oor4_8000 got %h expected %h", inst4, FILL); end
    fetch_at(16'h0000);
    nVectors++; if (inst8 !== 28'h0A) begin nMiscompares++; $display("[TB] FAIL dut8_mem0 got %h expected %h", inst8, 28'h0A); end
    fetch_at(16'h0100);
    nVectors++; if (inst8 !== FILL) begin nMiscompares++; $display("[TB] FAIL oor8_0100 got %h expected %h", inst8, FILL); end
    nVectors++; if (valid8 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL oor8_valid got %b expected 1", valid8); end
  endtask

  task automatic test_saturate();
    logic [4:0] expCount;
    iLoadMode = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      iLoadWrite = 1'b1; iLoadData = 28'h100 + 28'(i);
      tick();
      expCount = (i + 1 > 16) ? 5'd16 : 5'(i + 1);
      nVectors++; if (count4 !== expCount) begin nMiscompares++; $display("[TB] FAIL sat_count[%0d] got %0d expected %0d", i, count4, expCount); end
    end
    iLoadWrite = 1'b0; iLoadMode = 1'b0;
    tick();
    fetch_at(16'd0);
    nVectors++; if (inst4 !== 28'h100) begin nMiscompares++; $display("[TB] FAIL sat_mem0 got %h expected %h", inst4, 28'h100); end
    fetch_at(16'd3);
    nVectors++; if (inst4 !== 28'h103) begin nMiscompares++; $display("[TB] FAIL sat_mem3 got %h expected %h", inst4, 28'h103); end
    fetch_at(16'd15);
    nVectors++; if (inst4 !== 28'h10F) begin nMiscompares++; $display("[TB] FAIL sat_mem15 got %h expected %h", inst4, 28'h10F); end
  endtask

  task automatic test_back_to_back();
    iLoadMode = 1'b1;
    tick();
    iLoadWrite = 1'b1; iLoadData = 28'h5A5; iLoadMode = 1'b0;
    tick();
    iLoadWrite = 1'b0;
    nVectors++; if (ready4 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL b2b_ready got %b expected 1", ready4); end
    nVectors++; if (count4 !== 5'd1) begin nMiscompares++; $display("[TB] FAIL b2b_count got %0d expected 1", count4); end
    fetch_at(16'd0);
    nVectors++; if (inst4 !== 28'h5A5) begin nMiscompares++; $display("[TB] FAIL b2b_mem0 got %h expected %h", inst4, 28'h5A5); end
    fetch_at(16'd1);
    nVectors++; if (inst4 !== 28'h101) begin nMiscompares++; $display("[TB] FAIL b2b_retain1 got %h expected %h", inst4, 28'h101); end
  endtask

  task automatic test_reset_mid_load();
    iLoadMode = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      iLoadWrite = 1'b1; iLoadData = 28'hF00 + 28'(i);
      tick();
    end
    iLoadWrite = 1'b0;
    nVectors++; if (count4 !== 5'd5) begin nMiscompares++; $display("[TB] FAIL mid_count5 got %0d expected 5", count4); end
    Reset = 1'b0;
    #1;
    nVectors++; if (inst4 !== 28'h0) begin nMiscompares++; $display("[TB] FAIL rst_now_inst got %h expected %h", inst4, 28'h0); end
    nVectors++; if (count4 !== 5'd0) begin nMiscompares++; $display("[TB] FAIL rst_now_count got %0d expected 0", count4); end
    nVectors++; if (ready4 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rst_now_ready got %b expected 0", ready4); end
    nVectors++; if (valid4 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rst_now_valid got %b expected 0", valid4); end
    tick(); tick();
    iLoadMode = 1'b1; iLoadWrite = 1'b1; iLoadData = 28'hBAD;
    Reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) begin
        nVectors++; if (ready4 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reinit_ready_early got %b expected 0", ready4); end
      end
      if (k == 16) begin
        nVectors++; if (ready4 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reinit_ready_16 got %b expected 1", ready4); end
        nVectors++; if (count4 !== 5'd0) begin nMiscompares++; $display("[TB] FAIL init_ignores_write got %0d expected 0", count4); end
        iLoadWrite = 1'b0;
      end
    end
    tick();
    nVectors++; if (ready4 !== 1'b0) begin nMiscompares++; $display("[TB] FAIL held_loadmode got %b expected 0", ready4); end
    iLoadMode = 1'b0;
    tick();
    nVectors++; if (ready4 !== 1'b1) begin nMiscompares++; $display("[TB] FAIL back_to_run got %b expected 1", ready4); end
    for (int a = 0; a < 16; a++) begin
      fetch_at(16'(a));
      nVectors++; if (inst4 !== FILL) begin nMiscompares++; $display("[TB] FAIL refill[%0d] got %h expected %h", a, inst4, FILL); end
    end
  endtask

  initial begin
    test_reset();
    test_fill_fetch();
    test_load_three();
    test_out_of_range();
    test_saturate();
    test_back_to_back();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/instr_mem_loadable.md
INSTR_MEM_LOADABLE -- requirements
Module: instr_mem_loadable

Interface
REQ-001 The block SHALL have parameter DATA_W, default 28, meaning instruction word width.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning storage index width; DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have parameter FILL_WORD, default {LED opcode, 24'b10101010}, meaning the word stored in unprogrammed locations.
REQ-004 The block SHALL have port Clock, input, 1, the single clock.
REQ-005 The block SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port iAddress, input, 16, fetch address.
REQ-007 The block SHALL have port iFetch, input, 1, fetch request.
REQ-008 The block SHALL have port oInstruction, output, DATA_W, fetched word.
REQ-009 The block SHALL have port oValid, output, 1, oInstruction valid this cycle.
REQ-010 The block SHALL have port iLoadMode, input, 1, request to enter program-load mode.
REQ-011 The block SHALL have port iLoadWrite, input, 1, load-data strobe.
REQ-012 The block SHALL have port iLoadData, input, DATA_W, word to store.
REQ-013 The block SHALL have port oReady, output, 1, memory initialised and in RUN.
REQ-014 The block SHALL have port oLoadCount, output, ADDR_W+1, words written in the current load session.

Function
REQ-015 The FSM SHALL have states INIT, RUN and LOAD.
REQ-016 INIT SHALL write FILL_WORD to locations 0..DEPTH-1, one per cycle, then enter RUN, DEPTH cycles total.
REQ-017 In RUN with iFetch=1, oInstruction SHALL present mem[iAddress] on the next rising edge with oValid=1 (latency 1).
REQ-018 In RUN with iFetch=0, oValid SHALL be 0 and oInstruction SHALL hold its last value.
REQ-019 When iAddress >= DEPTH, the fetch SHALL return FILL_WORD with oValid=1; upper bits SHALL never alias.
REQ-020 RUN SHALL go to LOAD when iLoadMode=1; entering LOAD SHALL clear the load pointer and oLoadCount to 0.
REQ-021 In LOAD, each cycle with iLoadWrite=1 SHALL store iLoadData at the pointer, then increment the pointer and oLoadCount.
REQ-022 In LOAD, when oLoadCount reaches DEPTH, further writes SHALL be ignored, with no wrap and oLoadCount saturated.
REQ-023 In LOAD, fetches SHALL be ignored, and oValid and oReady SHALL be 0.
REQ-024 LOAD SHALL return to RUN on the cycle iLoadMode=0.
REQ-025 When iLoadWrite and the iLoadMode deassertion coincide, the write SHALL complete before the return to RUN.
REQ-026 Locations not written in a load session SHALL retain prior contents.
REQ-027 iLoadMode and iLoadWrite SHALL be ignored during INIT; a held iLoadMode SHALL take effect in the first RUN cycle.
REQ-028 oReady SHALL be 1 only in RUN.

Reset
REQ-029 Reset low SHALL immediately force the state to INIT, the init counter and load pointer to 0, oInstruction to 0, oValid to 0, oReady to 0 and oLoadCount to 0.
REQ-030 Reset asserted mid-LOAD or mid-INIT SHALL abandon the operation; INIT SHALL restart from location 0 after release.
REQ-031 Memory contents SHALL NOT be reset directly; only INIT clears them.

Structure
REQ-032 FSM state encoding, FILL_WORD default and opcode/colour definitions SHALL live in the shared definitions package.
REQ-033 Storage SHALL be a sub-module, instr_mem_ram: simple dual-port synchronous RAM with one write port, one registered read port and no reset.
REQ-034 The top level SHALL contain the FSM, counters and out-of-range mux only.

Verification
REQ-035 Release reset with ADDR_W=4 and fetch addresses 0..15 after oReady: oReady SHALL rise 16 cycles after release, and every fetch SHALL return FILL_WORD with oValid one cycle after iFetch.
REQ-036 Load 3 words 0x0A, 0x0B, 0x0C, drop iLoadMode, and fetch 0,1,2,3: the fetches SHALL return 0x0A, 0x0B, 0x0C, FILL_WORD, and oLoadCount SHALL be 3.
REQ-037 In LOAD with ADDR_W=4, write 20 words: oLoadCount SHALL saturate at 16, and address 0 SHALL hold the first word, not word 17.
REQ-038 Fetch iAddress=16'h0100 with ADDR_W=8: the fetch SHALL return FILL_WORD, not mem[0].
REQ-039 Assert Reset after 5 load writes: outputs SHALL zero immediately, oReady SHALL return after DEPTH cycles, and all locations SHALL read FILL_WORD.
REQ-040 Drive iLoadWrite=1 on the same cycle iLoadMode falls: the word SHALL be stored, and oReady SHALL be 1 the following cycle.
